// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and frame-length helper
//
// Purpose: common definitions for uart_tx and uart_rx.
// Contents: default widths, FSM state codes, line levels, frame_cycles().
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DIV_WIDTH  = 16;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Line levels; the idle line sits at the stop level
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Total clock cycles of one character frame
  function automatic int unsigned frame_cycles(input int unsigned div_val,
                                               input int unsigned data_width,
                                               input logic        parity_en,
                                               input logic        two_stop);
    return (div_val + 1) * (1 + data_width + (parity_en ? 1 : 0) + (two_stop ? 2 : 1));
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - load/decrement bit-time counter
//
// Purpose: times one bit period; bit_end is high in the last cycle of the bit.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   load        - reload counter with load_val (start of a new bit)
//   load_val    - cycles in the bit minus one
//   bit_end     - counter has reached zero
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int WIDTH = DEF_DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             bit_end
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign bit_end = (r_cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmit serializer draining the TX byte FIFO
//
// Purpose: pops a byte when the line is free and sends start, data (LSB first),
//          optional parity and one or two stop bits on txd.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   tx_en              - permits starting new frames
//   div                - clocks per bit minus one
//   parity_en/odd      - parity enable / odd-parity select
//   two_stop           - two stop bits
//   fifo_empty/data    - FIFO status and head-of-queue byte
//   fifo_re            - one-cycle pop strobe
//   txd, busy          - registered serial line and frame-active flag
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_re,
  output logic                  txd,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_bit_cnt;   // data bit index, reused as stop bit index
  logic [DIV_WIDTH-1:0]  r_div;
  logic                  r_par_en;
  logic                  r_par_odd;
  logic                  r_two_stop;
  logic                  r_par;       // XOR of data bits already sent
  logic                  r_txd;
  logic                  r_busy;

  logic                  w_bit_end;
  logic                  w_pop_cond;
  logic                  w_last_stop;
  logic                  w_baud_load;
  logic [DIV_WIDTH-1:0]  w_baud_val;
  logic [DATA_WIDTH-1:0] w_shift_next;

  assign w_pop_cond   = tx_en && !fifo_empty && !reset;
  assign w_last_stop  = (r_state == ST_STOP) && w_bit_end && (r_bit_cnt == CW'(r_two_stop));
  assign fifo_re      = w_pop_cond && ((r_state == ST_IDLE) || w_last_stop);
  // A new frame takes the live divisor; later bits use the latched copy
  assign w_baud_load  = fifo_re || ((r_state != ST_IDLE) && w_bit_end && !w_last_stop);
  assign w_baud_val   = fifo_re ? div : r_div;
  assign w_shift_next = r_shift >> 1;

  uart_baud_counter #(.WIDTH(DIV_WIDTH)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .load     (w_baud_load),
    .load_val (w_baud_val),
    .bit_end  (w_bit_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_div      <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
      r_par      <= 1'b0;
      r_txd      <= LINE_STOP;
      r_busy     <= 1'b0;
    end else if (fifo_re) begin
      r_shift    <= fifo_data;
      r_div      <= div;
      r_par_en   <= parity_en;
      r_par_odd  <= parity_odd;
      r_two_stop <= two_stop;
      r_par      <= 1'b0;
      r_bit_cnt  <= '0;
      r_state    <= ST_START;
      r_txd      <= LINE_START;
      r_busy     <= 1'b1;
    end else if ((r_state != ST_IDLE) && w_bit_end) begin
      case (r_state)
        ST_START: begin
          r_state <= ST_DATA;
          r_txd   <= r_shift[0];
        end
        ST_DATA: begin
          r_shift <= w_shift_next;
          r_par   <= r_par ^ r_shift[0];
          if (r_bit_cnt == CW'(DATA_WIDTH - 1)) begin
            r_bit_cnt <= '0;
            if (r_par_en) begin
              r_state <= ST_PARITY;
              r_txd   <= r_par ^ r_shift[0] ^ r_par_odd;
            end else begin
              r_state <= ST_STOP;
              r_txd   <= LINE_STOP;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
            r_txd     <= w_shift_next[0];
          end
        end
        ST_PARITY: begin
          r_state   <= ST_STOP;
          r_txd     <= LINE_STOP;
          r_bit_cnt <= '0;
        end
        ST_STOP: begin
          if (w_last_stop) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_txd   <= LINE_STOP;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign txd  = r_txd;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_en;
  logic [15:0] div;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_re;
  logic        txd;
  logic        busy;

  logic [7:0]  mem [0:15];
  int          wp = 0;
  int          rp = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);
  assign fifo_data  = mem[rp[3:0]];

  always @(posedge clk) if (fifo_re) rp <= rp + 1;

  uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_en      (tx_en),
    .div        (div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .txd        (txd),
    .busy       (busy)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp[3:0]] = b;
    wp++;
  endtask

  task automatic wait_pop(input string tag);
    int n = 0;
    #1;
    while (fifo_re !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, " pop"}, {31'b0, fifo_re}, 32'd1);
  endtask

  // bits: line value per bit time, first bit in bit 0; starts in the pop cycle
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                             input int dv, input logic exp_next, input int chg_at);
    int total = nbits * (dv + 1);
    for (int k = 0; k < total; k++) begin
      if (k == chg_at) begin
        tx_en = 1'b0;
        div   = 16'd5;
      end
      step();
      chk($sformatf("%s txd[%0d]", tag, k), {31'b0, txd}, {31'b0, bits[k / (dv + 1)]});
      chk($sformatf("%s busy[%0d]", tag, k), {31'b0, busy}, 32'd1);
      chk($sformatf("%s re[%0d]", tag, k), {31'b0, fifo_re},
          (k == total - 1) ? {31'b0, exp_next} : 32'd0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    tx_en      = 1'b1;
    div        = 16'd3;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    push(8'h55);
    repeat (3) step();
    chk("reset txd", {31'b0, txd}, 32'd1);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset re", {31'b0, fifo_re}, 32'd0);
    chk("reset pops", rp, 32'd0);

    // 0x55, div=3, no parity, one stop: 40 cycles
    reset = 1'b0;
    wait_pop("f55");
    check_frame("f55", {6'b0, 1'b1, 8'h55, 1'b0}, 10, 3, 1'b0, -1);
    step();
    chk("f55 idle busy", {31'b0, busy}, 32'd0);
    chk("f55 idle txd", {31'b0, txd}, 32'd1);
    chk("f55 pops", rp, 32'd1);

    // 0x07 even parity -> parity bit 1
    div = 16'd0; parity_en = 1'b1; parity_odd = 1'b0;
    push(8'h07);
    wait_pop("p07");
    check_frame("p07", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 0, 1'b0, -1);
    step();
    chk("p07 idle busy", {31'b0, busy}, 32'd0);

    // 0x00 odd parity -> parity bit 1
    parity_odd = 1'b1;
    push(8'h00);
    wait_pop("p00");
    check_frame("p00", {5'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 0, 1'b0, -1);
    step();
    chk("p00 idle busy", {31'b0, busy}, 32'd0);
    chk("parity pops", rp, 32'd3);

    // three queued bytes, div=1, two stop bits: 22-cycle frames, no gap
    parity_en = 1'b0; parity_odd = 1'b0; div = 16'd1; two_stop = 1'b1;
    push(8'h3C); push(8'hA5); push(8'h81);
    wait_pop("b2b");
    check_frame("b2b0", {5'b0, 2'b11, 8'h3C, 1'b0}, 11, 1, 1'b1, -1);
    check_frame("b2b1", {5'b0, 2'b11, 8'hA5, 1'b0}, 11, 1, 1'b1, -1);
    check_frame("b2b2", {5'b0, 2'b11, 8'h81, 1'b0}, 11, 1, 1'b0, -1);
    step();
    chk("b2b idle busy", {31'b0, busy}, 32'd0);
    chk("b2b pops", rp, 32'd6);

    // empty FIFO with tx_en=1: nothing happens
    two_stop = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk($sformatf("empty[%0d] re/txd/busy", i), {29'b0, fifo_re, txd, busy}, 32'b010);
    end

    // reset in the middle of DATA
    div = 16'd7;
    push(8'hA3); push(8'h5A);
    wait_pop("rst");
    repeat (36) step();
    chk("rst pre txd", {31'b0, txd}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst async txd", {31'b0, txd}, 32'd1);
    chk("rst async busy", {31'b0, busy}, 32'd0);
    chk("rst async re", {31'b0, fifo_re}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst hold[%0d] re/txd/busy", i), {29'b0, fifo_re, txd, busy}, 32'b010);
    end
    chk("rst pops", rp, 32'd7);
    reset = 1'b0;
    wait_pop("r5A");
    check_frame("r5A", {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 7, 1'b0, -1);
    step();
    chk("r5A idle busy", {31'b0, busy}, 32'd0);
    chk("r5A pops", rp, 32'd8);

    // tx_en dropped and div changed during DATA: frame finishes at div=2
    div = 16'd2;
    push(8'hC3); push(8'h11);
    wait_pop("tC3");
    check_frame("tC3", {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 2, 1'b0, 12);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("txoff[%0d] re/busy/txd", i), {29'b0, fifo_re, busy, txd}, 32'b001);
    end
    chk("txoff pops", rp, 32'd9);
    tx_en = 1'b1;
    wait_pop("t11");
    check_frame("t11", {6'b0, 1'b1, 8'h11, 1'b0}, 10, 5, 1'b0, -1);
    step();
    chk("t11 idle busy", {31'b0, busy}, 32'd0);
    chk("t11 pops", rp, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
